// File: rtl/rr_shared_reg_arbiter.sv
// Round-robin arbiter and write sequencer for a single shared WIDTH-bit register.
// Grants one requester at a time and supports locked bursts capped at MAX_BURST beats.
module rr_shared_reg_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_i,
    input  logic [N_REQ-1:0]           lock_i,
    input  logic [N_REQ*WIDTH-1:0]     data_i,
    output logic [N_REQ-1:0]           gnt_o,
    output logic [$clog2(N_REQ)-1:0]   owner_o,
    output logic [WIDTH-1:0]           q_o,
    output logic                       q_valid_o
);

    localparam int unsigned OW = $clog2(N_REQ);
    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    typedef enum logic {StIdle, StGrant} state_e;

    state_e           state_q;
    logic [OW-1:0]    ptr_q;
    logic [OW-1:0]    owner_q;
    logic [CW-1:0]    beat_cnt_q;
    logic [N_REQ-1:0] gnt_q;
    logic [WIDTH-1:0] q_q;
    logic             q_valid_q;

    logic [OW-1:0]    winner;
    logic [OW-1:0]    scan_idx;
    logic             found;
    logic             beat;
    logic             stay;

    // Scan requesters starting at the round-robin pointer; first hit wins.
    always_comb begin
        winner   = '0;
        scan_idx = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            scan_idx = OW'((32'(ptr_q) + i) % N_REQ);
            if (!found && req_i[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    assign beat = req_i[owner_q];
    assign stay = beat && lock_i[owner_q] && ((32'(beat_cnt_q) + 32'd1) < MAX_BURST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
            gnt_q      <= '0;
            q_q        <= '0;
            q_valid_q  <= 1'b0;
        end else begin
            q_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_i != '0) begin
                        state_q    <= StGrant;
                        gnt_q      <= N_REQ'(1) << winner;
                        owner_q    <= winner;
                        beat_cnt_q <= '0;
                    end
                end
                StGrant: begin
                    if (beat) begin
                        q_q        <= data_i[32'(owner_q)*WIDTH +: WIDTH];
                        q_valid_q  <= 1'b1;
                        beat_cnt_q <= beat_cnt_q + CW'(1);
                    end
                    // Every release passes through IDLE and advances the pointer past the owner.
                    if (!stay) begin
                        state_q <= StIdle;
                        gnt_q   <= '0;
                        ptr_q   <= (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + OW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign gnt_o     = gnt_q;
    assign owner_o   = owner_q;
    assign q_o       = q_q;
    assign q_valid_o = q_valid_q;

endmodule

// File: tb/tb_rr_shared_reg_arbiter.sv
// Bench for rr_shared_reg_arbiter: directed stimulus pushes expected grants and writes
// (with the cycle they must appear in) into queues; a negedge monitor pops and compares.
module tb_rr_shared_reg_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic [7:0]  q;
    logic        q_valid;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int         cyc;
        logic [3:0] gnt;
        logic [1:0] owner;
    } gnt_exp_t;

    typedef struct {
        int         cyc;
        logic [7:0] d;
        logic [1:0] owner;
    } wr_exp_t;

    gnt_exp_t gnt_qu[$];
    wr_exp_t  wr_qu[$];

    rr_shared_reg_arbiter #(
        .N_REQ    (4),
        .WIDTH    (8),
        .MAX_BURST(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_i    (req),
        .lock_i   (lock),
        .data_i   (data),
        .gnt_o    (gnt),
        .owner_o  (owner),
        .q_o      (q),
        .q_valid_o(q_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
        end
    endtask

    task automatic exp_gnt(input int dc, input int idx);
        gnt_exp_t e;
        e.cyc   = cyc + dc;
        e.gnt   = 4'b0001 << idx;
        e.owner = 2'(idx);
        gnt_qu.push_back(e);
    endtask

    task automatic exp_wr(input int dc, input logic [7:0] d, input int idx);
        wr_exp_t e;
        e.cyc   = cyc + dc;
        e.d     = d;
        e.owner = 2'(idx);
        wr_qu.push_back(e);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_gnt"}, 32'(gnt), 32'h0);
        chk({name, "_owner"}, 32'(owner), 32'h0);
        chk({name, "_q"}, 32'(q), 32'h0);
        chk({name, "_qvalid"}, 32'(q_valid), 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        chk_zero("reset_pulse");
        reset = 1'b0;
    endtask

    // Monitor: every grant cycle and every write pulse must match the next expectation.
    always @(negedge clk) begin
        if (gnt != 4'b0000) begin
            total++;
            if (gnt_qu.size() == 0) begin
                bad++;
                $display("FAIL gnt_unexpected cyc=%0d got=%b want=none", cyc, gnt);
            end else begin
                gnt_exp_t e;
                e = gnt_qu.pop_front();
                if (e.cyc != cyc || e.gnt !== gnt || e.owner !== owner) begin
                    bad++;
                    $display("FAIL gnt cyc=%0d got=%b/own%0d want=%b/own%0d@cyc%0d",
                             cyc, gnt, owner, e.gnt, e.owner, e.cyc);
                end
            end
        end
        if (q_valid) begin
            total++;
            if (wr_qu.size() == 0) begin
                bad++;
                $display("FAIL wr_unexpected cyc=%0d got=%0h want=none", cyc, q);
            end else begin
                wr_exp_t e;
                e = wr_qu.pop_front();
                if (e.cyc != cyc || e.d !== q || e.owner !== owner) begin
                    bad++;
                    $display("FAIL wr cyc=%0d got=%0h/own%0d want=%0h/own%0d@cyc%0d",
                             cyc, q, owner, e.d, e.owner, e.cyc);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        req   = 4'b1111;
        lock  = 4'b0000;
        data  = '0;

        // 1: reset with all requests pending, then requester 0 wins first.
        repeat (2) tick();
        chk_zero("reset");
        reset = 1'b0;
        exp_gnt(1, 0);
        tick();
        req = 4'b0000;
        tick();

        // 2: single unlocked write from requester 2 (pointer now 1).
        data[2*8 +: 8] = 8'hA5;
        req = 4'b0100;
        exp_gnt(1, 2);
        exp_wr(2, 8'hA5, 2);
        tick();
        tick();
        req = 4'b0000;
        chk("t2_owner", 32'(owner), 32'd2);
        chk("t2_q", 32'(q), 32'hA5);
        tick();
        do_reset();

        // 3: all requesting, no lock: 0,1,2,3,0 with an IDLE bubble between grants.
        for (int k = 0; k < 4; k++) data[k*8 +: 8] = 8'h30 + 8'(k);
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            exp_gnt(1 + 2*j, j % 4);
            exp_wr(2 + 2*j, 8'h30 + 8'(j % 4), j % 4);
        end
        repeat (10) tick();
        req = 4'b0000;
        tick();
        do_reset();

        // 4: locked burst from 0 capped at 4 beats, then requester 1 gets the grant.
        req  = 4'b0011;
        lock = 4'b0001;
        for (int i = 1; i <= 4; i++) exp_gnt(i, 0);
        for (int i = 0; i < 4; i++) exp_wr(2 + i, 8'h10 + 8'(i), 0);
        exp_gnt(6, 1);
        for (int i = 0; i < 5; i++) begin
            data[7:0] = 8'h0F + 8'(i);
            tick();
        end
        req  = 4'b0010;
        lock = 4'b0000;
        tick();

        // 5: requester 1 withdraws in its grant cycle: no write, pointer moves to 2.
        req = 4'b0000;
        tick();
        chk("t5_q_hold", 32'(q), 32'h13);
        chk("t5_qvalid", 32'(q_valid), 32'h0);
        chk("t5_gnt", 32'(gnt), 32'h0);
        chk("t5_owner", 32'(owner), 32'd1);
        req = 4'b1011;
        exp_gnt(1, 3);
        tick();
        req = 4'b0000;
        tick();

        // 6: reset during beat 2 of a locked burst from requester 2.
        data[2*8 +: 8] = 8'h60;
        req  = 4'b0100;
        lock = 4'b0100;
        exp_gnt(1, 2);
        exp_gnt(2, 2);
        exp_wr(2, 8'h60, 2);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk_zero("t6_mid_burst_reset");
        reset = 1'b0;
        req   = 4'b1111;
        lock  = 4'b0000;
        exp_gnt(1, 0);
        tick();
        req = 4'b0000;
        repeat (3) tick();

        chk("gnt_queue_drained", 32'(gnt_qu.size()), 32'd0);
        chk("wr_queue_drained", 32'(wr_qu.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
